aclint_mh: RTL and testbench

Multi-hart ACLINT: one shared 64-bit `mtime` with a programmable tick prescaler, plus per-hart `mtimecmp` (MTIMER) and `msip` (MSWI) registers. It is memory-mapped on the core's MMIO read/write port, uses a CLINT-compatible layout, and drives registered machine-timer and machine-software interrupt lines to each hart. It is the parametrised successor to the single-hart timer block.

---
 rtl/aclint_mh.sv | 170 +++++++++++++++++
 tb/tb_aclint_mh.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclint_mh.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aclint_mh                                                     |
// | Desc     : Multi-hart ACLINT. Shared prescaled 64-bit mtime, per-hart    |
// |            mtimecmp (MTIMER) and msip (MSWI) on a CLINT-style MMIO map.  |
// | Revision : 1.0 - initial parametrised multi-hart release                 |
// +--------------------------------------------------------------------------+
module aclint_mh #(
  parameter int unsigned NUM_HARTS    = 2,
  parameter logic [31:0] BASE_ADDR    = 32'hFF01_0000,
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IN_re,
  input  logic [29:0]          IN_raddr,
  output logic [31:0]          OUT_rdata,
  output logic                 OUT_rbusy,
  output logic                 OUT_rvalid,
  input  logic                 IN_we,
  input  logic [3:0]           IN_wmask,
  input  logic [29:0]          IN_waddr,
  input  logic [31:0]          IN_wdata,
  output logic [63:0]          OUT_mtime,
  output logic [NUM_HARTS-1:0] OUT_timerIRQ,
  output logic [NUM_HARTS-1:0] OUT_softIRQ
);

  localparam int unsigned          c_div_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_div_w-1:0]   c_div_last = c_div_w'(TICK_DIV - 1);

  // Decoded target of one word address; every flag already includes the window hit.
  typedef struct packed {
    logic       msip;
    logic       cmp;
    logic       mtime;
    logic       hi;
    logic [5:0] hart;
  } dec_t;

  function automatic dec_t decode(input logic [29:0] a);
    dec_t        d;
    logic        win;
    logic [13:0] w;
    logic [12:0] cidx;
    d    = '0;
    w    = a[13:0];
    cidx = w[13:1] - 13'h0800;
    win  = (a[29:14] == BASE_ADDR[31:16]);
    d.hi = w[0];
    if (w[13:12] == 2'b00) begin
      d.hart = w[5:0];
      d.msip = win && (32'(w[11:0]) < NUM_HARTS);
    end else if (w < 14'h2FFE) begin
      d.hart = cidx[5:0];
      d.cmp  = win && (32'(cidx) < NUM_HARTS);
    end else begin
      d.mtime = win && (w[13:1] == 13'h17FF);
    end
    return d;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

  dec_t                        w_rdec;
  dec_t                        w_wdec;
  logic                        w_rd_win;
  logic                        w_tick;
  logic                        w_wr_mtime;
  logic [31:0]                 w_rd_val;
  logic [31:0]                 w_hart_or;
  logic [NUM_HARTS-1:0][31:0]  w_hart_rd;

  logic [c_div_w-1:0]          r_div_cnt;
  logic [63:0]                 r_mtime;
  logic [31:0]                 r_rdata;
  logic                        r_rvalid;

  assign w_rdec     = decode(IN_raddr);
  assign w_wdec     = decode(IN_waddr);
  assign w_rd_win   = (IN_raddr[29:14] == BASE_ADDR[31:16]);
  assign w_tick     = (r_div_cnt == c_div_last);
  assign w_wr_mtime = IN_we && w_wdec.mtime;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_mtime   <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      // A software write replaces this cycle's tick; the prescaler keeps its phase.
      if (w_wr_mtime) begin
        if (w_wdec.hi) r_mtime[63:32] <= merge_bytes(r_mtime[63:32], IN_wdata, IN_wmask);
        else           r_mtime[31:0]  <= merge_bytes(r_mtime[31:0],  IN_wdata, IN_wmask);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic [63:0] r_cmp;
    logic        r_msip;
    logic        r_tirq;
    logic        w_wr_sel;
    logic        w_rd_sel;

    assign w_wr_sel = IN_we && (w_wdec.hart == 6'(h));
    assign w_rd_sel = (w_rdec.hart == 6'(h));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cmp  <= MTIMECMP_RST;
        r_msip <= 1'b0;
        r_tirq <= 1'b0;
      end else begin
        if (w_wr_sel && w_wdec.cmp) begin
          if (w_wdec.hi) r_cmp[63:32] <= merge_bytes(r_cmp[63:32], IN_wdata, IN_wmask);
          else           r_cmp[31:0]  <= merge_bytes(r_cmp[31:0],  IN_wdata, IN_wmask);
        end
        if (w_wr_sel && w_wdec.msip && IN_wmask[0]) r_msip <= IN_wdata[0];
        r_tirq <= (r_mtime >= r_cmp);
      end
    end

    assign w_hart_rd[h] = !w_rd_sel   ? 32'h0 :
                          w_rdec.msip ? {31'b0, r_msip} :
                          w_rdec.cmp  ? (w_rdec.hi ? r_cmp[63:32] : r_cmp[31:0]) :
                                        32'h0;
    assign OUT_timerIRQ[h] = r_tirq;
    assign OUT_softIRQ[h]  = r_msip;
  end

  // At most one hart contributes a non-zero word, so a per-bit OR is the mux.
  for (genvar b = 0; b < 32; b++) begin : g_rd_or
    logic [NUM_HARTS-1:0] w_col;
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_col
      assign w_col[h] = w_hart_rd[h][b];
    end
    assign w_hart_or[b] = |w_col;
  end

  assign w_rd_val = w_rdec.mtime ? (w_rdec.hi ? r_mtime[63:32] : r_mtime[31:0]) : w_hart_or;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= IN_re && w_rd_win;
      if (IN_re && w_rd_win) r_rdata <= w_rd_val;
    end
  end

  assign OUT_rdata  = r_rdata;
  assign OUT_rvalid = r_rvalid;
  assign OUT_rbusy  = 1'b0;
  assign OUT_mtime  = r_mtime;

endmodule
`default_nettype wire

// File: tb/tb_aclint_mh.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aclint_mh                                                  |
// | Desc     : Bench for aclint_mh: TICK_DIV=1 and TICK_DIV=4 instances      |
// |            against a behavioural model, plus directed literal checks.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_aclint_mh;
  localparam int          NH      = 2;
  localparam logic [31:0] BASE    = 32'hFF01_0000;
  localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re = 1'b0;
  logic [29:0] raddr = '0;
  logic        we = 1'b0;
  logic [3:0]  wmask = '0;
  logic [29:0] waddr = '0;
  logic [31:0] wdata = '0;

  logic [31:0]   rdata_o  [2];
  logic          rbusy_o  [2];
  logic          rvalid_o [2];
  logic [63:0]   mtime_o  [2];
  logic [NH-1:0] tirq_o   [2];
  logic [NH-1:0] sirq_o   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aclint_mh #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .TICK_DIV(1), .MTIMECMP_RST(CMP_RST)) u_dut1 (
    .clk(clk), .rst(rst), .IN_re(re), .IN_raddr(raddr), .OUT_rdata(rdata_o[0]),
    .OUT_rbusy(rbusy_o[0]), .OUT_rvalid(rvalid_o[0]), .IN_we(we), .IN_wmask(wmask),
    .IN_waddr(waddr), .IN_wdata(wdata), .OUT_mtime(mtime_o[0]),
    .OUT_timerIRQ(tirq_o[0]), .OUT_softIRQ(sirq_o[0]));

  aclint_mh #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .TICK_DIV(4), .MTIMECMP_RST(CMP_RST)) u_dut4 (
    .clk(clk), .rst(rst), .IN_re(re), .IN_raddr(raddr), .OUT_rdata(rdata_o[1]),
    .OUT_rbusy(rbusy_o[1]), .OUT_rvalid(rvalid_o[1]), .IN_we(we), .IN_wmask(wmask),
    .IN_waddr(waddr), .IN_wdata(wdata), .OUT_mtime(mtime_o[1]),
    .OUT_timerIRQ(tirq_o[1]), .OUT_softIRQ(sirq_o[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: TICK_DIV=1, 1: TICK_DIV=4)
  logic [63:0]     m_mtime  [2];
  logic [63:0]     m_cmp    [2][NH];
  logic            m_msip   [2][NH];
  logic            m_tirq   [2][NH];
  logic [31:0]     m_rdata  [2];
  logic            m_rvalid [2];
  longint unsigned m_cyc    [2];

  function automatic longint unsigned div_of(input int i);
    return (i == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic logic [31:0] off_of(input logic [29:0] a);
    return {a, 2'b00} - BASE;
  endfunction

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] read_val(input int i, input logic [31:0] off);
    int h;
    if (off < 32'h4000) begin
      h = int'(off / 4);
      if (h < NH) return {31'b0, m_msip[i][h]};
    end else if (off < 32'h4000 + 8 * NH) begin
      h = int'((off - 32'h4000) / 8);
      return off[2] ? m_cmp[i][h][63:32] : m_cmp[i][h][31:0];
    end else if (off == 32'hBFF8) begin
      return m_mtime[i][31:0];
    end else if (off == 32'hBFFC) begin
      return m_mtime[i][63:32];
    end
    return 32'h0;
  endfunction

  function automatic logic [63:0] next_mtime(input int i);
    logic [63:0] t;
    logic [31:0] off;
    t   = m_mtime[i];
    off = off_of(waddr);
    if (we && off == 32'hBFF8) return {t[63:32], bytes_merge(t[31:0], wdata, wmask)};
    if (we && off == 32'hBFFC) return {bytes_merge(t[63:32], wdata, wmask), t[31:0]};
    if (m_cyc[i] % div_of(i) == div_of(i) - 1) return t + 64'd1;
    return t;
  endfunction

  function automatic logic [63:0] next_cmp(input int i, input int h);
    logic [63:0] c;
    logic [31:0] off;
    c   = m_cmp[i][h];
    off = off_of(waddr);
    if (we && off == 32'h4000 + 8 * h) return {c[63:32], bytes_merge(c[31:0], wdata, wmask)};
    if (we && off == 32'h4004 + 8 * h) return {bytes_merge(c[63:32], wdata, wmask), c[31:0]};
    return c;
  endfunction

  function automatic logic next_msip(input int i, input int h);
    if (we && wmask[0] && off_of(waddr) == 32'(4 * h)) return wdata[0];
    return m_msip[i][h];
  endfunction

  function automatic logic [NH-1:0] pk_tirq(input int i);
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = m_tirq[i][h];
    return v;
  endfunction

  function automatic logic [NH-1:0] pk_msip(input int i);
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = m_msip[i][h];
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_mtime[i]  <= '0;
        m_cyc[i]    <= 0;
        m_rdata[i]  <= '0;
        m_rvalid[i] <= 1'b0;
        for (int h = 0; h < NH; h++) begin
          m_cmp[i][h]  <= CMP_RST;
          m_msip[i][h] <= 1'b0;
          m_tirq[i][h] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_rvalid[i] <= re && (off_of(raddr) < 32'h10000);
        if (re && off_of(raddr) < 32'h10000) m_rdata[i] <= read_val(i, off_of(raddr));
        m_mtime[i] <= next_mtime(i);
        m_cyc[i]   <= m_cyc[i] + 1;
        for (int h = 0; h < NH; h++) begin
          m_tirq[i][h] <= (m_mtime[i] >= m_cmp[i][h]);
          m_cmp[i][h]  <= next_cmp(i, h);
          m_msip[i][h] <= next_msip(i, h);
        end
      end
    end
  end

  // Every cycle, on the falling edge, all outputs of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("mtime[%0d]", i),  mtime_o[i],  m_mtime[i]);
      check($sformatf("rvalid[%0d]", i), rvalid_o[i], m_rvalid[i]);
      check($sformatf("rdata[%0d]", i),  rdata_o[i],  m_rdata[i]);
      check($sformatf("tirq[%0d]", i),   tirq_o[i],   pk_tirq(i));
      check($sformatf("sirq[%0d]", i),   sirq_o[i],   pk_msip(i));
      check($sformatf("rbusy[%0d]", i),  rbusy_o[i],  1'b0);
    end
  end

  // ---------------- stimulus (inputs change 1 time unit after the rising edge)
  task automatic do_write(input logic [31:0] off, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] a;
    a = BASE + off;
    we = 1'b1; waddr = a[31:2]; wdata = d; wmask = m;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] off);
    logic [31:0] a;
    a = BASE + off;
    re = 1'b1; raddr = a[31:2];
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic do_rw(input logic [31:0] off, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] a;
    a = BASE + off;
    re = 1'b1; raddr = a[31:2];
    we = 1'b1; waddr = a[31:2]; wdata = d; wmask = m;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  function automatic logic [29:0] pick_addr();
    logic [31:0] off;
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       off = 32'(4 * $urandom_range(0, 3));
      1, 2:    off = 32'h4000 + 32'(4 * $urandom_range(0, 5));
      3, 4:    off = 32'hBFF8 + 32'(4 * $urandom_range(0, 1));
      5:       off = 32'($urandom_range(0, 32'hFFFF)) & 32'hFFFC;
      6:       off = 32'h10000 + 32'(4 * $urandom_range(0, 3));
      7:       off = $urandom;
      default: off = 32'hBFF0 + 32'(4 * $urandom_range(0, 7));
    endcase
    a = BASE + off;
    return a[31:2];
  endfunction

  initial begin
    int t_ff;
    int t_zero;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mtime",  mtime_o[0],  64'h0);
    check("rst_rvalid", rvalid_o[1], 1'b0);
    check("rst_rdata",  rdata_o[1],  32'h0);
    check("rst_tirq",   tirq_o[0],   2'b00);
    check("rst_sirq",   sirq_o[1],   2'b00);

    // Reset and count
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("count_div1_after4", mtime_o[0], 64'd4);
    check("count_div4_after4", mtime_o[1], 64'd1);
    do_read(32'hBFF8);
    check("read_mtime_div1", rdata_o[0], 32'd4);
    check("read_mtime_div4", rdata_o[1], 32'd1);
    check("read_mtime_rvalid", rvalid_o[0], 1'b1);

    // Prescaler and wrap
    do_write(32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    do_write(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    check("wrap_loaded", mtime_o[1], 64'hFFFF_FFFF_FFFF_FFFE);
    t_ff = -1;
    t_zero = -1;
    for (int n = 0; n < 24 && t_zero < 0; n++) begin
      @(posedge clk); #1;
      if (t_ff < 0 && mtime_o[1] == 64'hFFFF_FFFF_FFFF_FFFF) t_ff = n;
      if (t_ff >= 0 && t_zero < 0 && mtime_o[1] == 64'h0) t_zero = n;
    end
    check("wrap_seen", (t_ff >= 0 && t_zero >= 0), 1'b1);
    check("wrap_spacing", 64'(t_zero - t_ff), 64'd4);
    do_read(32'hBFFC);
    check("wrap_upper_zero", rdata_o[1], 32'h0);

    // Timer IRQ on hart 1
    do_write(32'h4008, 32'd100, 4'hF);
    do_write(32'h400C, 32'd0,   4'hF);
    do_write(32'hBFFC, 32'd0,   4'hF);
    do_write(32'hBFF8, 32'd90,  4'hF);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk); #1;
      if (mtime_o[1] == 64'd100) found = 1'b1;
    end
    check("irq_reach100", found, 1'b1);
    check("irq1_lags", tirq_o[1][1], 1'b0);
    @(posedge clk); #1;
    check("irq1_rise", tirq_o[1][1], 1'b1);
    check("irq0_quiet", tirq_o[1][0], 1'b0);
    do_write(32'h400C, 32'hFFFF_FFFF, 4'hF);
    check("irq1_still_high", tirq_o[1][1], 1'b1);
    @(posedge clk); #1;
    check("irq1_cleared", tirq_o[1][1], 1'b0);
    do_write(32'h4008, 32'hFFFF_FFFF, 4'hF);

    // Partial-mask write
    do_write(32'h4000, 32'h0, 4'hF);
    do_write(32'h4004, 32'h0, 4'hF);
    do_write(32'h4004, 32'hAABB_CCDD, 4'b0101);
    do_read(32'h4004);
    check("pmask_hi", rdata_o[0], 32'h00BB_00DD);
    do_read(32'h4000);
    check("pmask_lo", rdata_o[1], 32'h0);

    // MSWI
    do_write(32'h0004, 32'hFFFF_FFFF, 4'b0001);
    check("msip_set", sirq_o[0], 2'b10);
    do_read(32'h0004);
    check("msip_read", rdata_o[0], 32'h1);
    do_write(32'h0004, 32'h0, 4'b1110);
    check("msip_mask_off", sirq_o[1], 2'b10);
    do_write(32'h0004, 32'h0, 4'b0001);
    check("msip_clr", sirq_o[0], 2'b00);

    // Boundaries
    do_read(32'h4010);
    check("unmapped_rdata", rdata_o[0], 32'h0);
    check("unmapped_rvalid", rvalid_o[0], 1'b1);
    do_read(32'h1_0000);
    check("outside_rvalid", rvalid_o[1], 1'b0);
    do_rw(32'h4000, 32'h1234_5678, 4'hF);
    check("rw_old", rdata_o[0], 32'h0);
    do_read(32'h4000);
    check("rw_new", rdata_o[1], 32'h1234_5678);

    // Randomised traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      re    = 1'($urandom_range(0, 1));
      raddr = pick_addr();
      we    = ($urandom_range(0, 2) == 0);
      waddr = pick_addr();
      wdata = $urandom;
      wmask = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      rst   = ($urandom_range(0, 199) != 0);
      @(posedge clk); #1;
    end
    re = 1'b0;
    we = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
